program_counter_stack: RTL and testbench

//   Parametrised successor to the A09 program counter. Holds the instruction

---
 rtl/program_counter_stack.sv | 119 +++++++++++
 tb/tb_program_counter_stack.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/program_counter_stack.sv
// Program counter with a hardware return-address stack for subroutine call and return.
// Define PC_REL_BRANCH_EN to enable PC-relative branching on Rel. Without it, Rel is ignored.
module program_counter_stack #(
   parameter int                   DataWidth    = 16,
   parameter int                   WordByteSize = 1,
   parameter int                   StackDepth   = 8,
   parameter logic [DataWidth-1:0] ResetVector  = '0
) (
   input  logic                               Clk,
   input  logic                               Reset,
   input  logic                               LD,
   input  logic                               Inc,
   input  logic                               Call,
   input  logic                               Ret,
   input  logic                               Rel,
   input  logic [DataWidth-1:0]               DIn,
   output logic [DataWidth-1:0]               DOut,
   output logic [DataWidth-1:0]               Tos,
   output logic [$clog2(StackDepth+1)-1:0]    Depth,
   output logic                               Full,
   output logic                               Empty,
   output logic                               Overflow,
   output logic                               Underflow
);

   localparam int DepW = $clog2(StackDepth + 1);
   localparam int IdxW = (StackDepth > 1) ? $clog2(StackDepth) : 1;

   logic [DataWidth-1:0] pc_q, pc_d;
   logic [DepW-1:0]      depth_q, depth_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;
   logic [DataWidth-1:0] mem_q [StackDepth];

   logic [DataWidth-1:0] step;
   logic [DataWidth-1:0] pc_next_seq;
   logic [DepW-1:0]      depth_m1;
   logic [IdxW-1:0]      wr_idx;
   logic [IdxW-1:0]      rd_idx;
   logic                 full;
   logic                 empty;
   logic                 push_en;

`ifndef PC_REL_BRANCH_EN
   logic unused_rel;
   assign unused_rel = Rel;
`endif

   assign step        = DataWidth'(WordByteSize);
   assign pc_next_seq = pc_q + step;
   assign depth_m1    = depth_q - DepW'(1);
   assign wr_idx      = IdxW'(depth_q);
   assign rd_idx      = IdxW'(depth_m1);
   assign full        = (depth_q == DepW'(StackDepth));
   assign empty       = (depth_q == '0);

   always_comb begin
      pc_d    = pc_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      if (Ret) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            pc_d    = mem_q[rd_idx];
            depth_d = depth_m1;
         end
      end else if (Call) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            push_en = 1'b1;
            pc_d    = DIn;
            depth_d = depth_q + DepW'(1);
         end
      end else if (LD) begin
         pc_d = DIn;
`ifdef PC_REL_BRANCH_EN
      end else if (Rel) begin
         // Unsigned add of the raw bits is the two's-complement signed add modulo 2^DataWidth.
         pc_d = pc_q + DIn;
`endif
      end else if (Inc) begin
         pc_d = pc_next_seq;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q    <= ResetVector;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack contents are not reset; Depth alone determines which entries are valid.
   always_ff @(posedge Clk) begin
      if (!Reset && push_en) begin
         mem_q[wr_idx] <= pc_next_seq;
      end
   end

   assign DOut      = pc_q;
   assign Tos       = empty ? '0 : mem_q[rd_idx];
   assign Depth     = depth_q;
   assign Full      = full;
   assign Empty     = empty;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Testbench for program_counter_stack: directed scenarios followed by random control traffic,
// all compared against a queue-based behavioural model.
module tb_program_counter_stack;

   localparam int          DW = 16;
   localparam int          SD = 8;
   localparam logic [15:0] RV = 16'h0010;

   logic          Clk = 1'b0;
   logic          Reset, LD, Inc, Call, Ret, Rel;
   logic [DW-1:0] DIn;
   logic [DW-1:0] DOut, Tos;
   logic [3:0]    Depth;
   logic          Full, Empty, Overflow, Underflow;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [15:0] m_pc;
   logic [15:0] m_stack[$];
   logic        m_ovf, m_unf;

   always #5 Clk = ~Clk;

   program_counter_stack #(
      .DataWidth(DW), .WordByteSize(1), .StackDepth(SD), .ResetVector(RV)
   ) dut (
      .Clk(Clk), .Reset(Reset), .LD(LD), .Inc(Inc), .Call(Call), .Ret(Ret), .Rel(Rel),
      .DIn(DIn), .DOut(DOut), .Tos(Tos), .Depth(Depth), .Full(Full), .Empty(Empty),
      .Overflow(Overflow), .Underflow(Underflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input logic r, ret, call, ld, rel, inc, input logic [15:0] din);
      if (r) begin
         m_pc = RV;
         m_stack.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (ret) begin
         if (m_stack.size() == 0) m_unf = 1'b1;
         else m_pc = m_stack.pop_back();
      end else if (call) begin
         if (m_stack.size() == SD) m_ovf = 1'b1;
         else begin
            m_stack.push_back(m_pc + 16'd1);
            m_pc = din;
         end
      end else if (ld) begin
         m_pc = din;
`ifdef PC_REL_BRANCH_EN
      end else if (rel) begin
         m_pc = m_pc + din;
`endif
      end else if (inc) begin
         m_pc = m_pc + 16'd1;
      end
   endtask

   task automatic compare_all();
      logic [15:0] exp_tos;
      exp_tos = (m_stack.size() == 0) ? 16'h0000 : m_stack[$];
      check("dout",      32'(DOut),      32'(m_pc));
      check("tos",       32'(Tos),       32'(exp_tos));
      check("depth",     32'(Depth),     32'(m_stack.size()));
      check("full",      32'(Full),      32'(m_stack.size() == SD));
      check("empty",     32'(Empty),     32'(m_stack.size() == 0));
      check("overflow",  32'(Overflow),  32'(m_ovf));
      check("underflow", 32'(Underflow), 32'(m_unf));
   endtask

   task automatic step(input logic r, ret, call, ld, rel, inc, input logic [15:0] din);
      @(negedge Clk);
      Reset = r; Ret = ret; Call = call; LD = ld; Rel = rel; Inc = inc; DIn = din;
      @(posedge Clk);
      model_update(r, ret, call, ld, rel, inc, din);
      #1;
      $display("txn rst=%0b ret=%0b call=%0b ld=%0b rel=%0b inc=%0b din=%h -> dout=%h tos=%h depth=%0d ovf=%0b unf=%0b",
               r, ret, call, ld, rel, inc, din, DOut, Tos, Depth, Overflow, Underflow);
      compare_all();
   endtask

   initial begin
      Reset = 1'b0; LD = 1'b0; Inc = 1'b0; Call = 1'b0; Ret = 1'b0; Rel = 1'b0; DIn = '0;
      m_pc = 16'h0; m_ovf = 1'b0; m_unf = 1'b0;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 16'h0);
      check("reset_dout", 32'(DOut), 32'h0010);
      check("reset_empty", 32'(Empty), 32'h1);

      // Sequential increments
      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 0, 0, 0, 1, 16'h0);
         check("inc_dout", 32'(DOut), 32'h0010 + 32'(i));
      end

      // Single call / return
      step(0, 0, 1, 0, 0, 0, 16'h0200);
      check("call_tos", 32'(Tos), 32'h0014);
      check("call_dout", 32'(DOut), 32'h0200);
      step(0, 1, 0, 0, 0, 0, 16'h0);
      check("ret_dout", 32'(DOut), 32'h0014);

      // Fill, overflow, LIFO unwind, underflow
      for (int i = 0; i < SD; i++) step(0, 0, 1, 0, 0, 0, 16'h1000 + 16'(i * 16));
      check("fill_full", 32'(Full), 32'h1);
      step(0, 0, 1, 0, 0, 0, 16'h0300);
      check("ovf_dout", 32'(DOut), 32'h1070);
      check("ovf_flag", 32'(Overflow), 32'h1);
      for (int i = SD - 1; i >= 0; i--) begin
         step(0, 1, 0, 0, 0, 0, 16'h0);
         check("unwind_dout", 32'(DOut), (i == 0) ? 32'h0015 : 32'h1001 + 32'((i - 1) * 16));
      end
      step(0, 1, 0, 0, 0, 0, 16'h0);
      check("unf_flag", 32'(Underflow), 32'h1);

      // Wrap and priority
      step(0, 0, 0, 1, 0, 0, 16'hFFFF);
      step(0, 0, 0, 0, 0, 1, 16'h0);
      check("wrap_dout", 32'(DOut), 32'h0000);
      step(0, 0, 1, 1, 0, 1, 16'h0500);
      check("prio_dout", 32'(DOut), 32'h0500);
      check("prio_tos", 32'(Tos), 32'h0001);
      step(0, 0, 1, 0, 0, 0, 16'hFFFF);
      step(0, 0, 1, 0, 0, 0, 16'h0000);
      check("wrap_push_tos", 32'(Tos), 32'h0000);

      // Relative branch
      step(0, 0, 0, 1, 0, 0, 16'h0100);
      step(0, 0, 0, 0, 1, 0, 16'hFFFC);
`ifdef PC_REL_BRANCH_EN
      check("rel_dout", 32'(DOut), 32'h00FC);
`else
      check("rel_dout", 32'(DOut), 32'h0100);
`endif

      // Reset mid-sequence discards the stack
      step(1, 0, 0, 0, 0, 0, 16'h0);
      check("midreset_depth", 32'(Depth), 32'h0);

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         logic r, ret, call, ld, rel, inc;
         logic [15:0] din;
         r    = ($urandom_range(0, 99) == 0);
         ret  = ($urandom_range(0, 99) < 30);
         call = ($urandom_range(0, 99) < 35);
         ld   = ($urandom_range(0, 99) < 15);
         rel  = ($urandom_range(0, 99) < 20);
         inc  = ($urandom_range(0, 99) < 50);
         din  = 16'($urandom);
         step(r, ret, call, ld, rel, inc, din);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
